// File: rtl/novacore_cfg_loader.sv
// Configuration transmitter for the NovaCORE fabric: serialises config records from a
// valid/ready stream into c_clk strobes, inserting c_dimswitch strobes on dimension changes.
module novacore_cfg_loader #(
  parameter int BUS_W     = 42,
  parameter int UID_W     = 7,
  parameter int DIM_W     = 2,
  parameter int SETUP_CYC = 2,
  parameter int HIGH_CYC  = 2,
  parameter int HOLD_CYC  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         rec_valid,
  output logic                         rec_ready,
  input  logic [UID_W+DIM_W+BUS_W-1:0] rec_data,
  input  logic                         rec_last,
  output logic                         busy,
  output logic                         done,
  output logic                         mode,
  output logic [BUS_W-1:0]             c_bus,
  output logic [UID_W-1:0]             c_uid,
  output logic                         c_clk,
  output logic [DIM_W-1:0]             c_dimension,
  output logic                         c_dimswitch
);

  localparam int REC_W   = UID_W + DIM_W + BUS_W;
  localparam int MAX_CYC = (SETUP_CYC > HIGH_CYC)
                         ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                         : ((HIGH_CYC  > HOLD_CYC) ? HIGH_CYC  : HOLD_CYC);
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  // Phase counter is loaded with (length - 1) and the phase ends when it reaches zero.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HIGH_LD  = CNT_W'(HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT, S_DSW_SETUP, S_DSW_HIGH, S_DSW_HOLD, S_SETUP, S_HIGH, S_HOLD, S_DONE
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               last_q;
  logic [DIM_W-1:0]   cur_dim;

  logic [UID_W-1:0]   in_uid;
  logic [DIM_W-1:0]   in_dim;
  logic [BUS_W-1:0]   in_word;

  assign in_uid  = rec_data[REC_W-1 -: UID_W];
  assign in_dim  = rec_data[BUS_W+DIM_W-1 -: DIM_W];
  assign in_word = rec_data[BUS_W-1:0];

  always_ff @(posedge clk) begin
    // NOTE: every register here, data included, is cleared by reset so the fabric
    // sees a defined bus and a dropped strobe in the very next cycle.
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      last_q      <= 1'b0;
      cur_dim     <= '0;
      rec_ready   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mode        <= 1'b0;
      c_bus       <= '0;
      c_uid       <= '0;
      c_clk       <= 1'b0;
      c_dimension <= '0;
      c_dimswitch <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge values and the default below is overridden only where set.
      done <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_WAIT;
            mode      <= 1'b0;
            busy      <= 1'b1;
            rec_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          if (rec_valid && rec_ready) begin
            rec_ready <= 1'b0;
            c_uid     <= in_uid;
            c_bus     <= in_word;
            last_q    <= rec_last;
            cnt       <= SETUP_LD;
            if (in_dim == cur_dim) begin
              state <= S_SETUP;
            end else begin
              state       <= S_DSW_SETUP;
              c_dimension <= in_dim;
            end
          end
        end
        S_DSW_SETUP: begin
          if (cnt == '0) begin
            state       <= S_DSW_HIGH;
            c_dimswitch <= 1'b1;
            cnt         <= HIGH_LD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_DSW_HIGH: begin
          if (cnt == '0) begin
            state       <= S_DSW_HOLD;
            c_dimswitch <= 1'b0;
            cnt         <= HOLD_LD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_DSW_HOLD: begin
          if (cnt == '0) begin
            state   <= S_SETUP;
            cur_dim <= c_dimension;
            cnt     <= SETUP_LD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_SETUP: begin
          if (cnt == '0) begin
            state <= S_HIGH;
            c_clk <= 1'b1;
            cnt   <= HIGH_LD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_HIGH: begin
          if (cnt == '0) begin
            state <= S_HOLD;
            c_clk <= 1'b0;
            cnt   <= HOLD_LD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (cnt == '0) begin
            if (last_q) begin
              state <= S_DONE;
              mode  <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state     <= S_WAIT;
              rec_ready <= 1'b1;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_novacore_cfg_loader.sv
// Directed bench for novacore_cfg_loader: three instances (2/2/2, 1/1/1, 3/4/5 timing)
// share clk/rst; each scenario task drives one instance and checks strobe timing cycle by cycle.
module tb_novacore_cfg_loader;

  localparam int NI    = 3;
  localparam int REC_W = 7 + 2 + 42;
  localparam int S_TAB [NI] = '{2, 1, 3};
  localparam int H_TAB [NI] = '{2, 1, 4};
  localparam int O_TAB [NI] = '{2, 1, 5};

  logic             clk;
  logic             rst;
  logic             start_v     [NI];
  logic             rec_valid_v [NI];
  logic             rec_last_v  [NI];
  logic [REC_W-1:0] rec_data_v  [NI];
  logic             rec_ready_v [NI];
  logic             busy_v      [NI];
  logic             done_v      [NI];
  logic             mode_v      [NI];
  logic [41:0]      c_bus_v     [NI];
  logic [6:0]       c_uid_v     [NI];
  logic             c_clk_v     [NI];
  logic [1:0]       c_dim_v     [NI];
  logic             c_dsw_v     [NI];

  int n_cmp = 0;
  int n_err = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    novacore_cfg_loader #(
      .BUS_W(42), .UID_W(7), .DIM_W(2),
      .SETUP_CYC(S_TAB[g]), .HIGH_CYC(H_TAB[g]), .HOLD_CYC(O_TAB[g])
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .start(start_v[g]),
      .rec_valid(rec_valid_v[g]),
      .rec_ready(rec_ready_v[g]),
      .rec_data(rec_data_v[g]),
      .rec_last(rec_last_v[g]),
      .busy(busy_v[g]),
      .done(done_v[g]),
      .mode(mode_v[g]),
      .c_bus(c_bus_v[g]),
      .c_uid(c_uid_v[g]),
      .c_clk(c_clk_v[g]),
      .c_dimension(c_dim_v[g]),
      .c_dimswitch(c_dsw_v[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic begin_session(input int k);
    start_v[k] = 1'b1;
    tick();
    start_v[k] = 1'b0;
    n_cmp++;
    if ({busy_v[k], mode_v[k], rec_ready_v[k]} !== 3'b101) begin
      n_err++;
      $display("FAIL session_open k=%0d got busy/mode/ready=%b exp=101", k,
               {busy_v[k], mode_v[k], rec_ready_v[k]});
    end
  endtask

  // Present a record and return at the first cycle after the accepting edge.
  task automatic send_rec(input int k, input logic [6:0] uid, input logic [1:0] dim,
                          input logic [41:0] word, input logic last, output int waited);
    rec_data_v[k]  = {uid, dim, word};
    rec_last_v[k]  = last;
    rec_valid_v[k] = 1'b1;
    waited = 0;
    while (rec_ready_v[k] !== 1'b1 && waited < 200) begin
      tick();
      waited++;
    end
    if (waited >= 200) begin
      n_cmp++;
      n_err++;
      $display("FAIL ready_timeout k=%0d got no ready exp ready within 200 cycles", k);
    end
    tick();
    rec_valid_v[k] = 1'b0;
    rec_last_v[k]  = 1'b0;
    rec_data_v[k]  = REC_W'({$urandom(), $urandom()});
  endtask

  // Checks cycles 1..n after accept; returns on cycle n (ready/done visible).
  task automatic check_record(input int k, input logic [6:0] uid, input logic [1:0] dim,
                              input logic [41:0] word, input logic sw);
    int s, h, t, n, base;
    logic exp_clk, exp_dsw;
    s = S_TAB[k];
    h = H_TAB[k];
    t = S_TAB[k] + H_TAB[k] + O_TAB[k];
    n = sw ? 2 * t + 1 : t + 1;
    base = sw ? t : 0;
    for (int c = 1; c <= n; c++) begin
      exp_dsw = sw && (c > s) && (c <= s + h);
      exp_clk = (c > base + s) && (c <= base + s + h);
      n_cmp++;
      if ({c_clk_v[k], c_dsw_v[k]} !== {exp_clk, exp_dsw}) begin
        n_err++;
        $display("FAIL strobe k=%0d cycle=%0d got clk/dsw=%b exp=%b", k, c,
                 {c_clk_v[k], c_dsw_v[k]}, {exp_clk, exp_dsw});
      end
      n_cmp++;
      if ({c_uid_v[k], c_dim_v[k], c_bus_v[k]} !== {uid, dim, word}) begin
        n_err++;
        $display("FAIL bus_stable k=%0d cycle=%0d got uid=%h dim=%h bus=%h exp uid=%h dim=%h bus=%h",
                 k, c, c_uid_v[k], c_dim_v[k], c_bus_v[k], uid, dim, word);
      end
      if (c < n) begin
        n_cmp++;
        if (rec_ready_v[k] !== 1'b0 || done_v[k] !== 1'b0) begin
          n_err++;
          $display("FAIL early_ready k=%0d cycle=%0d got ready/done=%b%b exp=00", k, c,
                   rec_ready_v[k], done_v[k]);
        end
        tick();
      end
    end
  endtask

  task automatic expect_done(input int k);
    n_cmp++;
    if ({done_v[k], mode_v[k], busy_v[k], rec_ready_v[k]} !== 4'b1100) begin
      n_err++;
      $display("FAIL done_pulse k=%0d got done/mode/busy/ready=%b exp=1100", k,
               {done_v[k], mode_v[k], busy_v[k], rec_ready_v[k]});
    end
    tick();
    n_cmp++;
    if ({done_v[k], mode_v[k], busy_v[k]} !== 3'b010) begin
      n_err++;
      $display("FAIL done_single k=%0d got done/mode/busy=%b exp=010", k,
               {done_v[k], mode_v[k], busy_v[k]});
    end
  endtask

  task automatic expect_next_ready(input int k);
    n_cmp++;
    if ({rec_ready_v[k], busy_v[k], done_v[k]} !== 3'b110) begin
      n_err++;
      $display("FAIL next_ready k=%0d got ready/busy/done=%b exp=110", k,
               {rec_ready_v[k], busy_v[k], done_v[k]});
    end
  endtask

  task automatic test_reset();
    int w;
    rst = 1'b1;
    tick();
    tick();
    for (int k = 0; k < NI; k++) begin
      n_cmp++;
      if ({mode_v[k], c_clk_v[k], c_dsw_v[k], rec_ready_v[k], busy_v[k], done_v[k],
           c_bus_v[k], c_uid_v[k], c_dim_v[k]} !== '0) begin
        n_err++;
        $display("FAIL reset_state k=%0d got nonzero outputs exp all zero", k);
      end
    end
    rst = 1'b0;
    begin_session(0);
    send_rec(0, 7'd7, 2'd0, 42'h155_5555_5555, 1'b1, w);
    tick();
    tick();
    n_cmp++;
    if (c_clk_v[0] !== 1'b1) begin
      n_err++;
      $display("FAIL reset_pre_high got c_clk=%b exp=1", c_clk_v[0]);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({c_clk_v[0], mode_v[0], busy_v[0], rec_ready_v[0], done_v[0]} !== 5'b0 ||
        c_bus_v[0] !== 42'h0) begin
      n_err++;
      $display("FAIL reset_mid_high got clk/mode/busy/ready/done=%b bus=%h exp=00000 bus=0",
               {c_clk_v[0], mode_v[0], busy_v[0], rec_ready_v[0], done_v[0]}, c_bus_v[0]);
    end
    tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({busy_v[0], rec_ready_v[0], c_clk_v[0]} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_idle got busy/ready/clk=%b exp=000",
               {busy_v[0], rec_ready_v[0], c_clk_v[0]});
    end
  endtask

  task automatic test_single(input int k);
    int w;
    begin_session(k);
    send_rec(k, 7'd5, 2'd0, 42'h2AB_CDEF_0123, 1'b1, w);
    check_record(k, 7'd5, 2'd0, 42'h2AB_CDEF_0123, 1'b0);
    expect_done(k);
  endtask

  task automatic test_dim_switch(input int k);
    int w;
    begin_session(k);
    send_rec(k, 7'd1, 2'd0, 42'h0F0_F0F0_F0F0, 1'b0, w);
    check_record(k, 7'd1, 2'd0, 42'h0F0_F0F0_F0F0, 1'b0);
    expect_next_ready(k);
    send_rec(k, 7'd2, 2'd2, 42'h30F_0F0F_0F0F, 1'b1, w);
    n_cmp++;
    if (w !== 0) begin
      n_err++;
      $display("FAIL back_to_back k=%0d got wait=%0d exp=0", k, w);
    end
    check_record(k, 7'd2, 2'd2, 42'h30F_0F0F_0F0F, 1'b1);
    expect_done(k);
  endtask

  task automatic test_back_pressure();
    int w;
    begin_session(0);
    send_rec(0, 7'd9, 2'd2, 42'h123_4567_89AB, 1'b0, w);
    check_record(0, 7'd9, 2'd2, 42'h123_4567_89AB, 1'b0);
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if ({rec_ready_v[0], busy_v[0], c_clk_v[0], c_dsw_v[0]} !== 4'b1100 ||
          {c_uid_v[0], c_dim_v[0], c_bus_v[0]} !== {7'd9, 2'd2, 42'h123_4567_89AB}) begin
        n_err++;
        $display("FAIL back_pressure idle=%0d got ready/busy/clk/dsw=%b bus=%h exp=1100 bus=12345678_9ab",
                 i, {rec_ready_v[0], busy_v[0], c_clk_v[0], c_dsw_v[0]}, c_bus_v[0]);
      end
      rec_data_v[0] = REC_W'({$urandom(), $urandom()});
      tick();
    end
    send_rec(0, 7'd10, 2'd2, 42'h3FF_0000_FFFF, 1'b1, w);
    n_cmp++;
    if (w !== 0) begin
      n_err++;
      $display("FAIL bp_ready_wait got wait=%0d exp=0", w);
    end
    check_record(0, 7'd10, 2'd2, 42'h3FF_0000_FFFF, 1'b0);
    expect_done(0);
  endtask

  task automatic test_start();
    int w;
    begin_session(0);
    send_rec(0, 7'd3, 2'd2, 42'h0AA_55AA_55AA, 1'b1, w);
    start_v[0] = 1'b1;
    tick();
    tick();
    start_v[0] = 1'b0;
    n_cmp++;
    if ({c_clk_v[0], rec_ready_v[0], busy_v[0], mode_v[0]} !== 4'b1010) begin
      n_err++;
      $display("FAIL start_ignored got clk/ready/busy/mode=%b exp=1010",
               {c_clk_v[0], rec_ready_v[0], busy_v[0], mode_v[0]});
    end
    for (int i = 0; i < 4; i++) tick();
    n_cmp++;
    if ({done_v[0], mode_v[0], busy_v[0]} !== 3'b110) begin
      n_err++;
      $display("FAIL start_done got done/mode/busy=%b exp=110",
               {done_v[0], mode_v[0], busy_v[0]});
    end
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    n_cmp++;
    if ({busy_v[0], mode_v[0], rec_ready_v[0], done_v[0]} !== 4'b1010) begin
      n_err++;
      $display("FAIL start_on_done got busy/mode/ready/done=%b exp=1010",
               {busy_v[0], mode_v[0], rec_ready_v[0], done_v[0]});
    end
    send_rec(0, 7'd4, 2'd1, 42'h001_0000_0001, 1'b1, w);
    check_record(0, 7'd4, 2'd1, 42'h001_0000_0001, 1'b1);
    expect_done(0);
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      start_v[k]     = 1'b0;
      rec_valid_v[k] = 1'b0;
      rec_last_v[k]  = 1'b0;
      rec_data_v[k]  = '0;
    end
    test_reset();
    for (int k = 0; k < NI; k++) test_single(k);
    for (int k = 0; k < NI; k++) test_dim_switch(k);
    test_back_pressure();
    test_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
